// File: rtl/proc_pkg.sv
// Shared encodings for the 6-instruction processor: opcodes, controller states,
// and the W_data / ALU select codes that the operational block also decodes.
package proc_pkg;

   typedef enum logic [3:0] {
      OP_LOAD  = 4'd0,
      OP_STORE = 4'd1,
      OP_ADD   = 4'd2,
      OP_LOADC = 4'd3,
      OP_SUB   = 4'd4,
      OP_JMPZ  = 4'd5
   } opcode_e;

   typedef enum logic [3:0] {
      ST_INIT     = 4'd0,
      ST_FETCH    = 4'd1,
      ST_DECODE   = 4'd2,
      ST_LOAD     = 4'd3,
      ST_STORE    = 4'd4,
      ST_ADD      = 4'd5,
      ST_LOADC    = 4'd6,
      ST_SUB      = 4'd7,
      ST_JMPZ     = 4'd8,
      ST_JMPZ_YES = 4'd9
   } state_e;

   typedef enum logic [1:0] {
      RF_S_ALU   = 2'b00,
      RF_S_DREG  = 2'b01,
      RF_S_WDATA = 2'b10
   } rf_s_e;

   typedef enum logic [1:0] {
      ALU_BYPASS = 2'b00,
      ALU_ADD    = 2'b01,
      ALU_SUB    = 2'b10
   } alu_s_e;

   // Opcodes 6..15 fall through to FETCH, i.e. they execute as NOPs.
   function automatic state_e state_for_op(input logic [3:0] op);
      case (op)
         OP_LOAD:  return ST_LOAD;
         OP_STORE: return ST_STORE;
         OP_ADD:   return ST_ADD;
         OP_LOADC: return ST_LOADC;
         OP_SUB:   return ST_SUB;
         OP_JMPZ:  return ST_JMPZ;
         default:  return ST_FETCH;
      endcase
   endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bus between the controller and instruction memory, data memory and the
// operational block (RF, ALU, W_data mux).
interface control_unit_if #(
   parameter int WIDTH    = 16,
   parameter int PC_WIDTH = 16,
   parameter int REGBITS  = 4,
   parameter int DBITS    = 8
);
   logic [WIDTH-1:0]    i_data;
   logic                rf_rp_zero;
   logic [PC_WIDTH-1:0] i_addr;
   logic                i_rd;
   logic [DBITS-1:0]    d_addr;
   logic                d_rd;
   logic                d_wr;
   logic [DBITS-1:0]    rf_w_data;
   logic [REGBITS-1:0]  rf_w_addr;
   logic                rf_w_wr;
   logic [REGBITS-1:0]  rf_rp_addr;
   logic                rf_rp_rd;
   logic [REGBITS-1:0]  rf_rq_addr;
   logic                rf_rq_rd;
   logic [1:0]          rf_s;
   logic [1:0]          alu_s;

   modport master (
      input  i_data, rf_rp_zero,
      output i_addr, i_rd, d_addr, d_rd, d_wr,
             rf_w_data, rf_w_addr, rf_w_wr,
             rf_rp_addr, rf_rp_rd, rf_rq_addr, rf_rq_rd,
             rf_s, alu_s
   );

   modport slave (
      output i_data, rf_rp_zero,
      input  i_addr, i_rd, d_addr, d_rd, d_wr,
             rf_w_data, rf_w_addr, rf_w_wr,
             rf_rp_addr, rf_rp_rd, rf_rq_addr, rf_rq_rd,
             rf_s, alu_s
   );
endinterface

// File: rtl/control_unit_program_counter.sv
// Program counter: clear, increment, or relative load of PC + sext(offset) - 1.
// All arithmetic wraps modulo 2^PC_WIDTH.
module program_counter #(
   parameter int PC_WIDTH = 16,
   parameter int DBITS    = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_clr,
   input  logic                i_inc,
   input  logic                i_ld,
   input  logic [DBITS-1:0]    i_offset,
   output logic [PC_WIDTH-1:0] o_pc
);

   logic [PC_WIDTH-1:0] r_pc;
   logic [PC_WIDTH-1:0] w_sext;
   logic [PC_WIDTH-1:0] w_target;

   assign w_sext   = {{(PC_WIDTH-DBITS){i_offset[DBITS-1]}}, i_offset};
   // The -1 undoes the increment already applied during FETCH.
   assign w_target = r_pc + w_sext - PC_WIDTH'(1);

   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_pc <= '0;
      end else if (i_ld) begin
         r_pc <= w_target;
      end else if (i_inc) begin
         r_pc <= r_pc + PC_WIDTH'(1);
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer: owns PC and IR, fetches, decodes, and emits one Moore
// control word per state to memories and the operational block.
//
// state       | meaning
// ------------+-------------------------------------------------------
// INIT        | clear PC and IR
// FETCH       | read imem at PC, latch IR, PC+1
// DECODE      | pick execute state from opcode (6..15 -> FETCH)
// LOAD        | RF[a] <= D[k]
// STORE       | D[k] <= RF[a]
// ADD / SUB   | RF[a] <= RF[b] +/- RF[c]
// LOADC       | RF[a] <= k
// JMPZ        | read RF[a]; branch taken if it is zero
// JMPZ_YES    | PC <= PC + sext(k) - 1
module control_unit
   import proc_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int PC_WIDTH = 16,
   parameter int REGBITS  = 4,
   parameter int DBITS    = 8
) (
   input  logic            clk,
   input  logic            reset,
   control_unit_if.master  bus
);

   state_e               r_state;
   logic [WIDTH-1:0]     r_ir;

   logic [3:0]           w_op;
   logic [REGBITS-1:0]   w_a;
   logic [REGBITS-1:0]   w_b;
   logic [REGBITS-1:0]   w_c;
   logic [DBITS-1:0]     w_k;
   logic [PC_WIDTH-1:0]  w_pc;

   logic                 w_pc_clr;
   logic                 w_pc_inc;
   logic                 w_pc_ld;

   logic                 w_i_rd;
   logic [DBITS-1:0]     w_d_addr;
   logic                 w_d_rd;
   logic                 w_d_wr;
   logic [DBITS-1:0]     w_rf_w_data;
   logic [REGBITS-1:0]   w_rf_w_addr;
   logic                 w_rf_w_wr;
   logic [REGBITS-1:0]   w_rf_rp_addr;
   logic                 w_rf_rp_rd;
   logic [REGBITS-1:0]   w_rf_rq_addr;
   logic                 w_rf_rq_rd;
   logic [1:0]           w_rf_s;
   logic [1:0]           w_alu_s;

   assign w_op = r_ir[15:12];
   assign w_a  = r_ir[11:8];
   assign w_b  = r_ir[7:4];
   assign w_c  = r_ir[3:0];
   assign w_k  = r_ir[7:0];

   assign w_pc_clr = (r_state == ST_INIT);
   assign w_pc_inc = (r_state == ST_FETCH);
   assign w_pc_ld  = (r_state == ST_JMPZ_YES);

   program_counter #(
      .PC_WIDTH (PC_WIDTH),
      .DBITS    (DBITS)
   ) u_pc (
      .clk      (clk),
      .reset    (reset),
      .i_clr    (w_pc_clr),
      .i_inc    (w_pc_inc),
      .i_ld     (w_pc_ld),
      .i_offset (w_k),
      .o_pc     (w_pc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_INIT;
         r_ir    <= '0;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_ir    <= '0;
               r_state <= ST_FETCH;
            end
            ST_FETCH: begin
               r_ir    <= bus.i_data;
               r_state <= ST_DECODE;
            end
            ST_DECODE: r_state <= state_for_op(w_op);
            ST_JMPZ:   r_state <= bus.rf_rp_zero ? ST_JMPZ_YES : ST_FETCH;
            default:   r_state <= ST_FETCH;
         endcase
      end
   end

   always_comb begin
      w_i_rd       = 1'b0;
      w_d_addr     = '0;
      w_d_rd       = 1'b0;
      w_d_wr       = 1'b0;
      w_rf_w_data  = '0;
      w_rf_w_addr  = '0;
      w_rf_w_wr    = 1'b0;
      w_rf_rp_addr = '0;
      w_rf_rp_rd   = 1'b0;
      w_rf_rq_addr = '0;
      w_rf_rq_rd   = 1'b0;
      w_rf_s       = RF_S_ALU;
      w_alu_s      = ALU_BYPASS;
      case (r_state)
         ST_FETCH: w_i_rd = 1'b1;
         ST_LOAD: begin
            w_d_addr    = w_k;
            w_d_rd      = 1'b1;
            w_rf_s      = RF_S_DREG;
            w_rf_w_addr = w_a;
            w_rf_w_wr   = 1'b1;
         end
         ST_STORE: begin
            w_d_addr     = w_k;
            w_d_wr       = 1'b1;
            w_rf_rp_addr = w_a;
            w_rf_rp_rd   = 1'b1;
         end
         ST_ADD, ST_SUB: begin
            w_rf_rp_addr = w_b;
            w_rf_rp_rd   = 1'b1;
            w_rf_rq_addr = w_c;
            w_rf_rq_rd   = 1'b1;
            w_alu_s      = (r_state == ST_ADD) ? ALU_ADD : ALU_SUB;
            w_rf_s       = RF_S_ALU;
            w_rf_w_addr  = w_a;
            w_rf_w_wr    = 1'b1;
         end
         ST_LOADC: begin
            w_rf_w_data = w_k;
            w_rf_s      = RF_S_WDATA;
            w_rf_w_addr = w_a;
            w_rf_w_wr   = 1'b1;
         end
         ST_JMPZ: begin
            w_rf_rp_addr = w_a;
            w_rf_rp_rd   = 1'b1;
         end
         default: ;
      endcase
   end

   // Reset kills every strobe immediately so an interrupted execute state writes nothing.
   assign bus.i_addr     = w_pc;
   assign bus.i_rd       = w_i_rd     & ~reset;
   assign bus.d_addr     = w_d_addr;
   assign bus.d_rd       = w_d_rd     & ~reset;
   assign bus.d_wr       = w_d_wr     & ~reset;
   assign bus.rf_w_data  = w_rf_w_data;
   assign bus.rf_w_addr  = w_rf_w_addr;
   assign bus.rf_w_wr    = w_rf_w_wr  & ~reset;
   assign bus.rf_rp_addr = w_rf_rp_addr;
   assign bus.rf_rp_rd   = w_rf_rp_rd & ~reset;
   assign bus.rf_rq_addr = w_rf_rq_addr;
   assign bus.rf_rq_rd   = w_rf_rq_rd & ~reset;
   assign bus.rf_s       = w_rf_s;
   assign bus.alu_s      = w_alu_s;

endmodule
